// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared action codes, PS/2 scan codes and receiver state type
package game_pkg;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_UP     = 3'd1,
    ACT_DOWN   = 3'd2,
    ACT_LEFT   = 3'd3,
    ACT_RIGHT  = 3'd4,
    ACT_SELECT = 3'd5,
    ACT_HALF   = 3'd6,
    ACT_CANCEL = 3'd7
  } action_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_J     = 8'h3B;
  localparam logic [7:0] KEY_Z     = 8'h1A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] EXT_UP    = 8'h75;
  localparam logic [7:0] EXT_DOWN  = 8'h72;
  localparam logic [7:0] EXT_LEFT  = 8'h6B;
  localparam logic [7:0] EXT_RIGHT = 8'h74;

  // Extended and plain code spaces are disjoint: WASD after E0 is deliberately unmapped.
  function automatic action_t map_code(input logic i_ext, input logic [7:0] i_code);
    action_t w_act;
    w_act = ACT_NONE;
    if (i_ext) begin
      case (i_code)
        EXT_UP:    w_act = ACT_UP;
        EXT_DOWN:  w_act = ACT_DOWN;
        EXT_LEFT:  w_act = ACT_LEFT;
        EXT_RIGHT: w_act = ACT_RIGHT;
        default:   w_act = ACT_NONE;
      endcase
    end else begin
      case (i_code)
        KEY_W:     w_act = ACT_UP;
        KEY_S:     w_act = ACT_DOWN;
        KEY_A:     w_act = ACT_LEFT;
        KEY_D:     w_act = ACT_RIGHT;
        KEY_SPACE: w_act = ACT_SELECT;
        KEY_J:     w_act = ACT_SELECT;
        KEY_Z:     w_act = ACT_HALF;
        KEY_ESC:   w_act = ACT_CANCEL;
        default:   w_act = ACT_NONE;
      endcase
    end
    return w_act;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 pin synchroniser, frame receiver FSM and inter-edge timeout
module ps2_rx
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_ps2_clock,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_frame_error
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [2:0]               r_clk_sync;
  logic [1:0]               r_dat_sync;
  rx_state_t                r_state;
  rx_state_t                w_next_state;
  logic [7:0]               r_shift;
  logic [2:0]               r_bit_cnt;
  logic                     r_parity;
  logic [TIMEOUT_WIDTH-1:0] r_tcnt;
  logic                     r_byte_valid;
  logic                     r_frame_error;
  logic                     w_fall;
  logic                     w_bit;
  logic                     w_timeout;
  logic                     w_ok;
  logic                     w_err;

  assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit     = r_dat_sync[1];
  assign w_timeout = (r_state != RX_IDLE) && !w_fall && (r_tcnt == TIMEOUT_LAST);

  always_comb begin
    w_next_state = r_state;
    w_ok         = 1'b0;
    w_err        = 1'b0;
    if (w_timeout) begin
      w_next_state = RX_IDLE;
      w_err        = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        RX_IDLE: begin
          if (!w_bit) w_next_state = RX_DATA;
          else        w_err        = 1'b1;
        end
        RX_DATA:   if (r_bit_cnt == 3'd7) w_next_state = RX_PARITY;
        RX_PARITY: w_next_state = RX_STOP;
        RX_STOP: begin
          w_next_state = RX_IDLE;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (w_bit && (^{r_shift, r_parity})) w_ok  = 1'b1;
          else                                w_err = 1'b1;
        end
        default: w_next_state = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clk_sync    <= 3'b111;
      r_dat_sync    <= 2'b11;
      r_state       <= RX_IDLE;
      r_shift       <= 8'd0;
      r_bit_cnt     <= 3'd0;
      r_parity      <= 1'b0;
      r_tcnt        <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_clk_sync    <= {r_clk_sync[1:0], i_ps2_clock};
      r_dat_sync    <= {r_dat_sync[0], i_ps2_data};
      r_state       <= w_next_state;
      r_byte_valid  <= w_ok;
      r_frame_error <= w_err;
      if (w_fall && !w_timeout) begin
        case (r_state)
          RX_IDLE: r_bit_cnt <= 3'd0;
          RX_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          RX_PARITY: r_parity <= w_bit;
          default:   r_parity <= r_parity;
        endcase
      end
      if (w_fall || w_timeout || r_state == RX_IDLE) r_tcnt <= '0;
      else                                           r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign o_byte_data   = r_shift;
  assign o_byte_valid  = r_byte_valid;
  assign o_frame_error = r_frame_error;

endmodule

// File: rtl/keyboard_decoder.sv
// rtl/keyboard_decoder.sv - strips E0/F0 prefixes and maps PS/2 make codes to game actions
module keyboard_decoder
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       keyboard_locker,
  output logic [2:0] keyboard_data,
  output logic       frame_error
);

  logic [7:0] w_byte_data;
  logic       w_byte_valid;
  logic       w_frame_error;
  action_t    w_action;
  logic       r_ext_flag;
  logic       r_brk_flag;
  logic       r_locker;
  logic [2:0] r_data;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_ps2_rx (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_ps2_clock  (ps2_clock),
    .i_ps2_data   (ps2_data),
    .o_byte_data  (w_byte_data),
    .o_byte_valid (w_byte_valid),
    .o_frame_error(w_frame_error)
  );

  assign w_action = map_code(r_ext_flag, w_byte_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
      r_locker   <= 1'b0;
      r_data     <= 3'd0;
    end else begin
      r_locker <= 1'b0;
      if (w_frame_error) begin
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte_data == PS2_EXT) begin
          r_ext_flag <= 1'b1;
        end else if (w_byte_data == PS2_BRK) begin
          r_brk_flag <= 1'b1;
        end else begin
          // A released key (break prefix seen) never produces an action.
          if (!r_brk_flag && w_action != ACT_NONE) begin
            r_data   <= w_action;
            r_locker <= 1'b1;
          end
          r_ext_flag <= 1'b0;
          r_brk_flag <= 1'b0;
        end
      end
    end
  end

  assign keyboard_locker = r_locker;
  assign keyboard_data   = r_data;
  assign frame_error     = w_frame_error;

endmodule

// File: tb/tb_keyboard_decoder.sv
// tb/tb_keyboard_decoder.sv - scoreboard bench for keyboard_decoder
module tb_keyboard_decoder;

  logic       clock;
  logic       reset;
  logic       ps2_clock;
  logic       ps2_data;
  logic       keyboard_locker;
  logic [2:0] keyboard_data;
  logic       frame_error;

  int         n_checks;
  int         n_errors;
  int         err_seen;
  logic [2:0] exp_q[$];
  logic [2:0] last_data;
  logic       prev_locker;

  keyboard_decoder #(
    .TIMEOUT_CYCLES(50),
    .TIMEOUT_WIDTH (6)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clock      (ps2_clock),
    .ps2_data       (ps2_data),
    .keyboard_locker(keyboard_locker),
    .keyboard_data  (keyboard_data),
    .frame_error    (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      prev_locker = 1'b0;
      last_data   = 3'd0;
    end else begin
      if (keyboard_locker && frame_error) begin
        n_checks++;
        n_errors++;
        $display("FAIL locker_and_error both high at %0t", $time);
      end
      if (keyboard_locker && prev_locker) begin
        n_checks++;
        n_errors++;
        $display("FAIL strobe_width locker high two cycles at %0t", $time);
      end
      if (keyboard_locker) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_strobe got data %0d expected no strobe", keyboard_data);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (keyboard_data !== e) begin
            n_errors++;
            $display("FAIL strobe_data got %0d expected %0d", keyboard_data, e);
          end
        end
        last_data = keyboard_data;
      end else if (keyboard_data !== last_data) begin
        n_checks++;
        n_errors++;
        $display("FAIL data_hold got %0d expected %0d", keyboard_data, last_data);
        last_data = keyboard_data;
      end
      if (frame_error) err_seen++;
      prev_locker = keyboard_locker;
    end
  end

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (5) @(posedge clock);
    ps2_clock = 1'b0;
    repeat (10) @(posedge clock);
    ps2_clock = 1'b1;
    repeat (5) @(posedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_parity);
    send_bit(1'b1);
  endtask

  task automatic settle_and_check(input string name, input int err_before, input int err_expect);
    repeat (20) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_missing_strobe pending %0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (err_seen - err_before !== err_expect) begin
      n_errors++;
      $display("FAIL %s_frame_errors got %0d expected %0d", name, err_seen - err_before, err_expect);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (keyboard_locker !== 1'b0 || keyboard_data !== 3'd0 || frame_error !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs got %b/%0d/%b expected 0/0/0", keyboard_locker, keyboard_data, frame_error);
    end
    reset = 1'b0;
    repeat (5) @(posedge clock);
  endtask

  task automatic test_make_w();
    int e0;
    e0 = err_seen;
    exp_q.push_back(3'd1);
    send_frame(8'h1D, 1'b0);
    settle_and_check("make_w", e0, 0);
  endtask

  task automatic test_start_error();
    int e0;
    e0 = err_seen;
    send_bit(1'b1);
    settle_and_check("start_error", e0, 1);
  endtask

  task automatic test_extended();
    int e0;
    e0 = err_seen;
    exp_q.push_back(3'd3);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);
    settle_and_check("ext_left", e0, 0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h6B, 1'b0);
    send_frame(8'h75, 1'b0);
    settle_and_check("ext_break", e0, 0);
  endtask

  task automatic test_parity_error();
    int e0;
    e0 = err_seen;
    send_frame(8'h29, 1'b1);
    settle_and_check("parity_bad", e0, 1);
    exp_q.push_back(3'd7);
    send_frame(8'h76, 1'b0);
    settle_and_check("parity_recover", e0, 1);
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_seen;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (100) @(posedge clock);
    settle_and_check("timeout", e0, 1);
    exp_q.push_back(3'd6);
    send_frame(8'h1A, 1'b0);
    settle_and_check("timeout_recover", e0, 1);
    send_frame(8'hE0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    repeat (100) @(posedge clock);
    send_frame(8'h74, 1'b0);
    settle_and_check("timeout_clears_ext", e0, 2);
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = err_seen;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(3'd1);
      send_frame(8'h1D, 1'b0);
    end
    exp_q.push_back(3'd5);
    send_frame(8'h3B, 1'b0);
    exp_q.push_back(3'd4);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    settle_and_check("typematic", e0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int         e0;
    logic [7:0] d;
    d = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    ps2_data = d[3];
    repeat (5) @(posedge clock);
    ps2_clock = 1'b0;
    repeat (3) @(posedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (keyboard_locker !== 1'b0 || keyboard_data !== 3'd0 || frame_error !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_outputs got %b/%0d/%b expected 0/0/0", keyboard_locker, keyboard_data, frame_error);
    end
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (3) @(posedge clock);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    e0 = err_seen;
    exp_q.push_back(3'd3);
    send_frame(8'h1C, 1'b0);
    settle_and_check("midreset_recover", e0, 0);
  endtask

  task automatic test_unmapped();
    int e0;
    e0 = err_seen;
    send_frame(8'h15, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1D, 1'b0);
    settle_and_check("unmapped", e0, 0);
    n_checks++;
    if (keyboard_data !== 3'd3) begin
      n_errors++;
      $display("FAIL unmapped_hold got %0d expected 3", keyboard_data);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    err_seen    = 0;
    last_data   = 3'd0;
    prev_locker = 1'b0;
    test_reset();
    test_make_w();
    test_start_error();
    test_extended();
    test_parity_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
